io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU IO space: the responder side of the IORead/IOWrite strobes that the control unit raises for lw/sw with address bits [31:10] all ones.
- Accepts byte writes into a small FIFO and serialises them 8N1 on uart_tx.
- Exposes status and baud-divisor registers to IORead.
- Its iordata output is OR-merged into the IO read mux, so it drives zero when not selected.

Parameters:
- BASE_ADDR, 10'h3F0, IO offset (ALU_result[9:0]) of register block; 16-bit aligned.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..16.
- DIV_RESET, 16'd434, reset value of the baud divisor, in clocks per bit.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- IORead, input, 1, IO read strobe from control unit; one clock per instruction.
- IOWrite, input, 1, IO write strobe from control unit.
- ioaddr, input, 10, ALU_result[9:0].
- iowdata, input, 16, store data (rt[15:0]).
- iordata, output, 16, read data; 16'h0000 when not selected.
- uart_tx, output, 1, serial line, idle high.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 TXDATA: write only; reads return 0.
  - +2 STATUS: read only.
  - +4 DIVISOR: read/write.
  - Any other offset: writes ignored, reads return 0.
- Selection is by exact 10-bit address match.
- STATUS layout:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM not IDLE)
  - bit3 overflow (sticky)
  - bits[8:4] fifo count
  - other bits 0
- iordata is combinational: IORead and address hit gives the register value; otherwise 16'h0000.
- Write to TXDATA (IOWrite high at the edge):
  - iowdata[7:0] is pushed if the FIFO is not full, evaluated before any same-edge pop.
  - If the FIFO is full, the byte is dropped and overflow is set.
  - Upper bits are ignored.
- overflow clears on the edge where IORead hits STATUS; iordata in that cycle still shows 1. If a set and a clear occur on the same edge, set wins.
- Write to DIVISOR:
  - Takes iowdata; a value of 0 is stored as 1.
  - Applies from the next frame start; a frame in flight keeps its latched divisor D.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1.
  - If the FIFO is non-empty: pop into the shift register, latch D, bit counter=0, go to START.
- Bit timing: each state bit lasts exactly D clocks, counted by a 16-bit baud counter.
  - START: uart_tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: uart_tx=1.
- End of STOP: if the FIFO is non-empty, pop and go directly to START (back-to-back frame = exactly 10*D clocks); else go to IDLE.
- Latency: TXDATA written at edge N with the FIFO empty and FSM IDLE → FIFO count 1 after N, pop at N+1, uart_tx falls after edge N+1.
- Simultaneous push and pop on the same edge: count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
- uart_tx is registered (glitch-free).
- Reset values:
  - uart_tx=1
  - FIFO empty, count 0
  - overflow=0
  - DIVISOR=DIV_RESET
  - FSM IDLE
  - iordata=0 (no strobe)
- Reset asserted mid-frame: line returns high immediately; all queued bytes are lost.

Test Plan:
- Reset then IORead STATUS (ioaddr=10'h3F2) → iordata=16'h0002; uart_tx=1; DIVISOR read (10'h3F4) → 16'd434.
- Write DIVISOR=4, then TXDATA=16'h00A5 → uart_tx low 4 clocks starting the cycle after the pop edge, then 1,0,1,0,0,1,0,1 each 4 clocks, then stop high 4 clocks; STATUS=16'h0002 afterwards.
- DIVISOR=2, write 5 bytes 0x11..0x15 on consecutive cycles while idle → first byte pops, four queue:
  - STATUS shows full=1, count=4, busy=1, overflow=0.
  - The sixth write is dropped with overflow=1.
  - Total line activity is 5 back-to-back frames of 20 clocks with no idle gap.
- Overflow set, then IORead STATUS → that read shows bit3=1; next read shows bit3=0.
- Write DIVISOR=0 → reads back 1. Write DIVISOR=8 mid-frame → current frame keeps the old D, next frame uses 8.
- Pulse reset_n low during DATA bit 3 → uart_tx=1 asynchronously, STATUS=16'h0002 after release. Also check that IORead/IOWrite to 10'h3F6 or 10'h3EE produces iordata=0 and no state change.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// IO-space bus between the control unit and the UART transmitter register block.
// master = CPU side, slave = peripheral side.
interface io_uart_tx_if;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  ioaddr;
  logic [15:0] iowdata;
  logic [15:0] iordata;

  modport master (
    output IORead,
    output IOWrite,
    output ioaddr,
    output iowdata,
    input  iordata
  );

  modport slave (
    input  IORead,
    input  IOWrite,
    input  ioaddr,
    input  iowdata,
    output iordata
  );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers on the CPU IO bus,
// a small byte FIFO and a registered serial output.
module io_uart_tx #(
  parameter logic [9:0]  BASE_ADDR  = 10'h3F0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clock,
  input  logic        reset_n,
  io_uart_tx_if.slave bus,
  output logic        uart_tx
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     div_lat_q, div_lat_d;
  logic            tx_q, tx_d;

  logic hit_tx, hit_st, hit_div;
  logic full, empty, busy, push, pop, ovf_set, baud_end;
  logic [15:0] status;

  assign hit_tx  = (bus.ioaddr == BASE_ADDR);
  assign hit_st  = (bus.ioaddr == BASE_ADDR + 10'd2);
  assign hit_div = (bus.ioaddr == BASE_ADDR + 10'd4);

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == 5'd0);
  assign busy    = (state_q != StIdle);
  // Fullness is judged on the pre-edge count, so a push never relies on a same-edge pop.
  assign push    = bus.IOWrite && hit_tx && !full;
  assign ovf_set = bus.IOWrite && hit_tx && full;

  assign baud_end = (baud_q == div_lat_q - 16'd1);
  assign status   = {7'd0, count_q, ovf_q, busy, empty, full};

  always_comb begin
    bus.iordata = 16'h0000;
    if (bus.IORead) begin
      if (hit_st) begin
        bus.iordata = status;
      end else if (hit_div) begin
        bus.iordata = div_q;
      end
    end
  end

  always_comb begin
    div_d = div_q;
    if (bus.IOWrite && hit_div) begin
      div_d = (bus.iowdata == 16'd0) ? 16'd1 : bus.iowdata;
    end
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (bus.IORead && hit_st) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = 16'd0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rptr_q];
          div_lat_d = div_q;
          bit_d     = 3'd0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = 16'd0;
          // Chain straight into the next start bit so queued frames run back to back.
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rptr_q];
            div_lat_d = div_q;
            bit_d     = 3'd0;
            tx_d      = 1'b0;
            state_d   = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !push) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= bus.iowdata[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      state_q   <= StIdle;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      div_lat_q <= DIV_RESET;
      tx_q      <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register vector table, a line monitor fed by a
// scoreboard of expected frames, and hand sequences for FIFO, divisor and reset corners.
module tb_io_uart_tx;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic uart_tx;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .BASE_ADDR (10'h3F0),
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd434)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  frame_t sb_q[$];
  vec_t   tbl[$];
  int     start_log[$];
  int     end_log[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     frames_done = 0;
  int     cur_div = 434;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line monitor: every frame is compared cycle by cycle against the scoreboard head.
  initial begin : monitor
    frame_t     f;
    logic [9:0] bits;
    int         bad;
    logic       bad_val;
    bit         aborted;
    int         s;
    forever begin
      @(negedge clock);
      if (reset_n && uart_tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("spurious_start", 16'(uart_tx), 16'h0001);
          while (uart_tx === 1'b0 && reset_n) @(negedge clock);
        end else begin
          f       = sb_q.pop_front();
          bits    = {1'b1, f.data, 1'b0};
          s       = cyc;
          bad     = -1;
          bad_val = 1'b0;
          aborted = 1'b0;
          for (int i = 0; i < 10 * f.div; i++) begin
            if (i != 0) @(negedge clock);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            if (bad < 0 && uart_tx !== bits[i / f.div]) begin
              bad     = i;
              bad_val = uart_tx;
            end
          end
          if (!aborted) begin
            checks++;
            if (bad >= 0) begin
              errors++;
              $display("FAIL frame_%h: line %b at frame cycle %0d, expected %b", f.data,
                       bad_val, bad, bits[bad / f.div]);
            end
            start_log.push_back(s);
            end_log.push_back(cyc + 1);
            frames_done++;
          end
        end
      end
    end
  end

  task automatic io_write(input logic [9:0] a, input logic [15:0] d);
    bus.IOWrite = 1'b1;
    bus.ioaddr  = a;
    bus.iowdata = d;
    @(negedge clock);
    bus.IOWrite = 1'b0;
  endtask

  task automatic io_read(input logic [9:0] a, input logic [15:0] exp, input string name);
    bus.IORead = 1'b1;
    bus.ioaddr = a;
    #1;
    check(name, bus.iordata, exp);
    @(negedge clock);
    bus.IORead = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    frame_t f;
    f.data = b;
    f.div  = cur_div;
    sb_q.push_back(f);
    io_write(10'h3F0, {8'hE7, b});
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (frames_done < n) begin
      errors++;
      $display("FAIL %s: frames_done %0d required %0d", name, frames_done, n);
    end
    @(negedge clock);
  endtask

  initial begin : main
    int idx;
    bus.IORead  = 1'b0;
    bus.IOWrite = 1'b0;
    bus.ioaddr  = 10'h000;
    bus.iowdata = 16'h0000;

    tbl.push_back('{1'b1, 1'b0, 10'h3F2, 16'h0000, 16'h0002, "st_reset"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F4, 16'h0000, 16'h01B2, "div_reset"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F0, 16'h0000, 16'h0000, "txdata_rd"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F6, 16'h0000, 16'h0000, "miss_3f6_rd"});
    tbl.push_back('{1'b1, 1'b0, 10'h3EE, 16'h0000, 16'h0000, "miss_3ee_rd"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F3, 16'h0000, 16'h0000, "odd_3f3_rd"});
    tbl.push_back('{1'b0, 1'b1, 10'h3F6, 16'hFFFF, 16'h0000, "miss_3f6_wr"});
    tbl.push_back('{1'b0, 1'b1, 10'h3EE, 16'h00AA, 16'h0000, "miss_3ee_wr"});
    tbl.push_back('{1'b0, 1'b0, 10'h3F2, 16'h0000, 16'h0000, "no_strobe"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F2, 16'h0000, 16'h0002, "st_after_miss"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F4, 16'h0000, 16'h01B2, "div_after_miss"});
    tbl.push_back('{1'b0, 1'b1, 10'h3F4, 16'h0000, 16'h0000, "div0_wr"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F4, 16'h0000, 16'h0001, "div0_rd"});
    tbl.push_back('{1'b0, 1'b1, 10'h3F4, 16'h0004, 16'h0000, "div4_wr"});
    tbl.push_back('{1'b1, 1'b0, 10'h3F4, 16'h0000, 16'h0004, "div4_rd"});

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("tx_idle_reset", 16'(uart_tx), 16'h0001);

    foreach (tbl[i]) begin
      bus.IORead  = tbl[i].rd;
      bus.IOWrite = tbl[i].wr;
      bus.ioaddr  = tbl[i].addr;
      bus.iowdata = tbl[i].wdata;
      #1;
      check(tbl[i].name, bus.iordata, tbl[i].exp);
      @(negedge clock);
      bus.IORead  = 1'b0;
      bus.IOWrite = 1'b0;
    end
    cur_div = 4;

    // Single frame: pop one edge after the write, start bit from the following cycle.
    push_byte(8'hA5);
    check("lat_before_pop", 16'(uart_tx), 16'h0001);
    @(negedge clock);
    check("lat_start", 16'(uart_tx), 16'h0000);
    io_read(10'h3F2, 16'h0006, "st_busy_empty");
    wait_frames(1, 100, "frame_a5_done");
    io_read(10'h3F2, 16'h0002, "st_after_a5");

    // Burst: fill the FIFO, drop a sixth byte, then five back-to-back frames.
    io_write(10'h3F4, 16'h0002);
    cur_div = 2;
    idx = start_log.size();
    for (int b = 0; b < 5; b++) push_byte(8'h11 + 8'(b));
    io_write(10'h3F0, 16'h0016);
    io_read(10'h3F2, 16'h004D, "st_full_ovf");
    io_read(10'h3F2, 16'h0045, "st_ovf_cleared");
    wait_frames(6, 200, "burst_done");
    if (end_log.size() >= idx + 5)
      check("burst_span", 16'(end_log[idx+4] - start_log[idx]), 16'd100);
    else
      check("burst_logged", 16'(end_log.size()), 16'(idx + 5));
    io_read(10'h3F2, 16'h0002, "st_after_burst");

    // Divisor change mid-frame only affects the next frame.
    io_write(10'h3F4, 16'h0004);
    cur_div = 4;
    push_byte(8'h3C);
    repeat (6) @(negedge clock);
    io_write(10'h3F4, 16'h0008);
    cur_div = 8;
    push_byte(8'hC3);
    io_read(10'h3F4, 16'h0008, "div8_rd");
    wait_frames(8, 300, "div_change_done");
    idx = start_log.size();
    if (idx >= 2) begin
      check("len_old_div", 16'(end_log[idx-2] - start_log[idx-2]), 16'd40);
      check("len_new_div", 16'(end_log[idx-1] - start_log[idx-1]), 16'd80);
    end else begin
      check("div_frames_logged", 16'(idx), 16'd2);
    end

    // Reset during data bit 3 with a second byte queued.
    io_write(10'h3F4, 16'h0004);
    cur_div = 4;
    push_byte(8'h00);
    push_byte(8'h55);
    repeat (17) @(negedge clock);
    check("tx_bit3_low", 16'(uart_tx), 16'h0000);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("tx_async_reset", 16'(uart_tx), 16'h0001);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    cur_div = 434;
    io_read(10'h3F2, 16'h0002, "st_after_reset");
    io_read(10'h3F4, 16'h01B2, "div_after_reset");
    repeat (40) @(negedge clock);
    check("tx_idle_after_reset", 16'(uart_tx), 16'h0001);
    check("sb_drained", 16'(sb_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
